// File: rtl/lcd_write_queue_if.sv
// lcd_write_queue_if
// Bundles the CPU-side write strobe, the LCD-controller handshake and the
// queue status signals of lcd_write_queue.
//   wr_en, wr_data : one-cycle write strobe and word from the memory controller
//   ovf_clr        : clears the sticky overflow flag
//   out_ready      : LCD controller accepts the head word this cycle
//   out_valid      : head word is present on out_data
//   out_data       : head-of-queue word, 0 when out_valid is low
//   full, count    : occupancy status (count spans 0..DEPTH)
//   overflow       : sticky flag, a write was dropped while full
// master: the side that writes words and consumes them (CPU + LCD controller).
// slave : the queue itself.
interface lcd_write_queue_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;
  logic              ovf_clr;
  logic              out_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output wr_en, wr_data, ovf_clr, out_ready,
    input  out_valid, out_data, full, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, out_ready,
    output out_valid, out_data, full, count, overflow
  );
endinterface

// File: rtl/lcd_write_queue.sv
// lcd_write_queue
// First-word-fall-through queue between the memory controller's LCD write
// strobe and the LCD controller. CPU words are buffered so bursts of stores
// do not overwrite words the LCD controller has not yet taken. Writes that
// arrive while the queue is full (and nothing is leaving) are dropped and
// recorded in a sticky overflow flag.
// Ports:
//   CLK_50MHZ : system clock, all state updates on its rising edge
//   reset     : synchronous active-high reset
//   bus       : lcd_write_queue_if slave (write strobe, output handshake,
//               status: full, count, overflow)
module lcd_write_queue #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK_50MHZ,
  input  logic              reset,
  lcd_write_queue_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow;

  logic valid;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Status comes from the registered count only, so out_valid never
  // depends combinationally on out_ready.
  always_comb begin
    valid = (count != '0);
    full  = (count == DEPTH_CNT);
    pop   = valid & bus.out_ready;
    // A write into a full queue still fits when the head leaves this cycle.
    push  = bus.wr_en & (~full | pop);
    drop  = bus.wr_en & full & ~pop;
  end

  // Storage is not reset; only the pointers define what is live.
  always_ff @(posedge CLK_50MHZ) begin
    if (!reset && push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      overflow <= drop | (overflow & ~bus.ovf_clr);
    end
  end

  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? mem[rd_ptr] : '0;
  assign bus.full      = full;
  assign bus.count     = count;
  assign bus.overflow  = overflow;

endmodule
